// File: rtl/ser_word_collector_if.sv
// ----------------------------------------------------------------------------
// ser_word_collector_if
//   Bundles the serial input stream, the parallel word handshake and the
//   status outputs of ser_word_collector.
//
//   Signals
//     clk_en        one-cycle advance pulse
//     ser_in        serial data bit
//     ser_in_valid  serial data qualifier
//     par_ack       consumer accepts par_out this cycle
//     par_out       last completed word, MSB = first bit received
//     par_valid     par_out holds an unconsumed word
//     bit_cnt       bits collected in the current partial word
//     overrun       sticky: a completed word was dropped
//     busy          collector is in the middle of a word
//
//   Modports
//     master  drives the stream and the ack, observes the outputs
//     slave   the collector itself
// ----------------------------------------------------------------------------
interface ser_word_collector_if #(
    parameter int WIDTH = 8
);
    logic             clk_en;
    logic             ser_in;
    logic             ser_in_valid;
    logic             par_ack;
    logic [WIDTH-1:0] par_out;
    logic             par_valid;
    logic [3:0]       bit_cnt;
    logic             overrun;
    logic             busy;

    modport master (
        output clk_en, ser_in, ser_in_valid, par_ack,
        input  par_out, par_valid, bit_cnt, overrun, busy
    );

    modport slave (
        input  clk_en, ser_in, ser_in_valid, par_ack,
        output par_out, par_valid, bit_cnt, overrun, busy
    );
endinterface

// File: rtl/ser_word_collector.sv
// ----------------------------------------------------------------------------
// ser_word_collector
//   Samples a serial bit stream on clk_en pulses (while ser_in_valid is high),
//   assembles MSB-first words of WIDTH bits and offers each completed word on
//   a parallel port with a valid/ack handshake. A completed word that finds
//   the output still occupied (and not being acked) is dropped and raises a
//   sticky overrun flag.
//
//   Ports
//     clk   system clock, all state changes on posedge
//     rst   synchronous, active-high reset; clears every register
//     bus   ser_word_collector_if.slave (stream in, word out, status)
//
//   Parameters
//     WIDTH  bits per word, 2..15 (bit_cnt is 4 bits wide)
// ----------------------------------------------------------------------------
module ser_word_collector #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    ser_word_collector_if.slave   bus
);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(WIDTH - 1);

    state_t           state_q,     state_d;
    logic [3:0]       bit_cnt_q,   bit_cnt_d;
    // Only WIDTH-1 history bits are kept; the newest bit completes the word.
    logic [WIDTH-2:0] sreg_q,      sreg_d;
    logic [WIDTH-1:0] par_out_q,   par_out_d;
    logic             par_valid_q, par_valid_d;
    logic             overrun_q,   overrun_d;

    logic             sample;
    logic             word_done;
    logic [WIDTH-1:0] shifted;

    assign sample  = bus.clk_en & bus.ser_in_valid;
    assign shifted = {sreg_q, bus.ser_in};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sreg_d      = sreg_q;
        word_done   = 1'b0;

        if (sample) begin
            sreg_d = shifted[WIDTH-2:0];
        end

        unique case (state_q)
            IDLE: begin
                if (sample) begin
                    state_d   = COLLECT;
                    bit_cnt_d = 4'd1;
                end
            end
            COLLECT: begin
                if (bus.clk_en) begin
                    if (!bus.ser_in_valid) begin
                        // Abort: the partial word is simply forgotten.
                        state_d   = IDLE;
                        bit_cnt_d = 4'd0;
                    end else if (bit_cnt_q == LAST_BIT) begin
                        word_done = 1'b1;
                        state_d   = IDLE;
                        bit_cnt_d = 4'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = 4'd0;
            end
        endcase

        // Handshake: an ack frees the slot in the same edge a new word may
        // claim it, so completion plus ack loads without overrun.
        par_out_d   = par_out_q;
        par_valid_d = par_valid_q & ~bus.par_ack;
        overrun_d   = overrun_q;
        if (word_done) begin
            if (par_valid_q && !bus.par_ack) begin
                overrun_d = 1'b1;
            end else begin
                par_out_d   = shifted;
                par_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 4'd0;
            sreg_q      <= '0;
            par_out_q   <= '0;
            par_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sreg_q      <= sreg_d;
            par_out_q   <= par_out_d;
            par_valid_q <= par_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.par_out   = par_out_q;
    assign bus.par_valid = par_valid_q;
    assign bus.bit_cnt   = bit_cnt_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = (state_q == COLLECT);

endmodule

// File: tb/tb_ser_word_collector.sv
// ----------------------------------------------------------------------------
// tb_ser_word_collector
//   Directed bench for ser_word_collector (WIDTH=8). A behavioural model of
//   the collector is advanced alongside the stimulus; every word the model
//   expects to appear on par_out is queued when its last bit is driven and
//   popped when the completing edge has passed.
// ----------------------------------------------------------------------------
module tb_ser_word_collector;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ser_word_collector_if #(.WIDTH(8)) bus ();

    ser_word_collector #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [3:0] m_cnt;
    logic [7:0] m_sreg;
    logic [7:0] m_out;
    logic       m_valid;
    logic       m_ovr;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_cnt   = 4'd0;
        m_sreg  = 8'h00;
        m_out   = 8'h00;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        exp_q.delete();
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".bit_cnt"},   16'(bus.bit_cnt),   16'(m_cnt));
        chk({tag, ".busy"},      16'(bus.busy),      16'(m_cnt != 4'd0));
        chk({tag, ".par_valid"}, 16'(bus.par_valid), 16'(m_valid));
        chk({tag, ".par_out"},   16'(bus.par_out),   16'(m_out));
        chk({tag, ".overrun"},   16'(bus.overrun),   16'(m_ovr));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One sample event, then two idle clocks (clk_en every 3rd clk).
    task automatic sample_bit(input logic b, input logic ack);
        logic       done;
        logic       accept;
        logic [7:0] w;
        bus.clk_en       = 1'b1;
        bus.ser_in_valid = 1'b1;
        bus.ser_in       = b;
        bus.par_ack      = ack;
        m_sreg = {m_sreg[6:0], b};
        done   = 1'b0;
        accept = 1'b0;
        if (m_cnt == 4'd7) begin
            done  = 1'b1;
            m_cnt = 4'd0;
        end else begin
            m_cnt = m_cnt + 4'd1;
        end
        if (done) begin
            if (m_valid && !ack) begin
                m_ovr = 1'b1;
            end else begin
                exp_q.push_back(m_sreg);
                m_out   = m_sreg;
                m_valid = 1'b1;
                accept  = 1'b1;
            end
        end else if (ack) begin
            m_valid = 1'b0;
        end
        tick();
        bus.clk_en       = 1'b0;
        bus.ser_in_valid = 1'b0;
        bus.par_ack      = 1'b0;
        chk_state("bit");
        if (accept) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 16'd1, 16'd0);
            end else begin
                w = exp_q.pop_front();
                chk("sb.par_out", 16'(bus.par_out), 16'(w));
            end
        end
        idle(2);
    endtask

    task automatic send_word(input logic [7:0] w, input logic ack_last);
        for (int i = 7; i >= 0; i--) begin
            sample_bit(w[i], (i == 0) ? ack_last : 1'b0);
        end
    endtask

    // clk_en with the qualifier low: aborts a partial word, otherwise no-op.
    task automatic pulse_invalid();
        bus.clk_en       = 1'b1;
        bus.ser_in_valid = 1'b0;
        tick();
        bus.clk_en = 1'b0;
        m_cnt = 4'd0;
        chk_state("inv");
    endtask

    task automatic ack_pulse();
        bus.par_ack = 1'b1;
        tick();
        bus.par_ack = 1'b0;
        m_valid = 1'b0;
        chk_state("ack");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.clk_en       = 1'b0;
        bus.ser_in       = 1'b0;
        bus.ser_in_valid = 1'b0;
        bus.par_ack      = 1'b0;
        model_reset();

        // 1. Reset for two cycles with activity on the inputs.
        rst              = 1'b1;
        bus.clk_en       = 1'b1;
        bus.ser_in_valid = 1'b1;
        bus.ser_in       = 1'b1;
        bus.par_ack      = 1'b1;
        tick();
        bus.ser_in = 1'b0;
        tick();
        bus.clk_en       = 1'b0;
        bus.ser_in_valid = 1'b0;
        bus.par_ack      = 1'b0;
        chk("rst.par_out",   16'(bus.par_out),   16'h0);
        chk("rst.par_valid", 16'(bus.par_valid), 16'h0);
        chk("rst.bit_cnt",   16'(bus.bit_cnt),   16'h0);
        chk("rst.overrun",   16'(bus.overrun),   16'h0);
        chk("rst.busy",      16'(bus.busy),      16'h0);
        rst = 1'b0;
        idle(1);
        chk_state("post_rst");

        // 2. First word 1,0,1,1,0,0,1,0.
        send_word(8'hB2, 1'b0);
        chk("t2.par_out",   16'(bus.par_out),   16'h00B2);
        chk("t2.par_valid", 16'(bus.par_valid), 16'h1);

        // 3. Unqualified clk_en is a no-op; ack releases the word.
        pulse_invalid();
        ack_pulse();
        chk("t3.par_out",   16'(bus.par_out),   16'h00B2);
        chk("t3.par_valid", 16'(bus.par_valid), 16'h0);

        // 4. Three bits, abort, then a full word.
        sample_bit(1'b1, 1'b0);
        sample_bit(1'b1, 1'b0);
        sample_bit(1'b1, 1'b0);
        pulse_invalid();
        send_word(8'h5A, 1'b0);
        chk("t4.par_out", 16'(bus.par_out), 16'h005A);
        chk("t4.overrun", 16'(bus.overrun), 16'h0);

        // 5. Overrun, then load on a same-edge ack.
        ack_pulse();
        send_word(8'h0F, 1'b0);
        send_word(8'hF0, 1'b0);
        chk("t5.par_out_keep", 16'(bus.par_out), 16'h000F);
        chk("t5.overrun",      16'(bus.overrun), 16'h1);
        send_word(8'h33, 1'b1);
        chk("t5.par_out_new",  16'(bus.par_out),   16'h0033);
        chk("t5.par_valid",    16'(bus.par_valid), 16'h1);
        chk("t5.overrun_stk",  16'(bus.overrun),   16'h1);

        // 6. Reset mid-word, then a clean word.
        for (int i = 0; i < 5; i++) sample_bit(1'(i & 1), 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk("t6.bit_cnt",   16'(bus.bit_cnt),   16'h0);
        chk("t6.overrun",   16'(bus.overrun),   16'h0);
        chk("t6.par_valid", 16'(bus.par_valid), 16'h0);
        chk("t6.busy",      16'(bus.busy),      16'h0);
        send_word(8'hC3, 1'b0);
        chk("t6.par_out",   16'(bus.par_out),   16'h00C3);
        chk("sb.drained",   16'(exp_q.size()),  16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
